// File: rtl/prach_hb4_sched.sv
// PRACH half-band-by-4 input scheduler.
// Collects TDM samples from two consecutive frames and pairs them per channel.
// The first frame after a sync (phase 0) fills a per-channel buffer. In the
// following frame (phase 1) each used channel issues one pair, made of the
// buffered even-phase sample and the live odd-phase sample.
//
// Handshake: din_dv qualifies din_dq/din_chn/sync_in for one clk cycle. There
// is no backpressure, so a valid input is always accepted on the rising edge
// where din_dv=1. dout_dv is a one-cycle pulse; the data and channel outputs
// hold their last values whenever dout_dv=0.
module prach_hb4_sched #(
  parameter int NUM_CHANNEL      = 128,
  parameter int NUM_CHANNEL_USED = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din_dq,
  input  logic        din_dv,
  input  logic [7:0]  din_chn,
  input  logic        sync_in,
  output logic [15:0] dout_dp1,
  output logic [15:0] dout_dp2,
  output logic        dout_dv,
  output logic [7:0]  dout_chn,
  output logic        sync_out,
  output logic        err_seq
);

  localparam int         AW       = (NUM_CHANNEL_USED > 1) ? $clog2(NUM_CHANNEL_USED) : 1;
  localparam logic [7:0] LAST_CHN = 8'(NUM_CHANNEL - 1);
  localparam logic [8:0] USED_LIM = 9'(NUM_CHANNEL_USED);

  // Control state
  logic [7:0]                  r_exp_chn;
  logic                        r_phase;
  logic                        r_sync_pend;
  logic                        r_err;
  logic [NUM_CHANNEL_USED-1:0] r_vbits;

  // Sample buffer (data needs no reset; the valid bits gate its use)
  logic [15:0] r_mem [NUM_CHANNEL_USED];

  // Two-stage pair pipeline
  logic        r_p1_vld, r_p1_sync;
  logic [7:0]  r_p1_chn;
  logic [15:0] r_p1_dq, r_p1_rd;
  logic        r_p2_vld, r_p2_sync;
  logic [7:0]  r_p2_chn;
  logic [15:0] r_p2_dq, r_p2_rd;

  // Output registers
  logic [15:0] r_dp1, r_dp2;
  logic [7:0]  r_chn;
  logic        r_dv, r_sync_out;

  logic                        w_used;
  logic                        w_last;
  logic                        w_eff_phase;
  logic [AW-1:0]               w_addr;
  logic                        w_write;
  logic                        w_issue;
  logic [7:0]                  w_next_chn;
  logic [NUM_CHANNEL_USED-1:0] w_vbits_nxt;

  // Decode of the current slot: which phase it belongs to and what it does
  always_comb begin
    w_used      = ({1'b0, din_chn} < USED_LIM);
    w_last      = (din_chn == LAST_CHN);
    w_eff_phase = sync_in ? 1'b0 : r_phase;
    w_addr      = din_chn[AW-1:0];
    w_write     = din_dv & w_used & ~w_eff_phase;
    w_issue     = din_dv & w_used & w_eff_phase & r_vbits[w_addr];
    w_next_chn  = w_last ? 8'd0 : din_chn + 8'd1;
    w_vbits_nxt = r_vbits;
    if (din_dv && sync_in) w_vbits_nxt = '0;
    if (w_write) w_vbits_nxt[w_addr] = 1'b1;
  end

  // Channel counter, phase, sync-pending, error flag and buffer valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_chn   <= 8'd0;
      r_phase     <= 1'b0;
      r_sync_pend <= 1'b0;
      r_err       <= 1'b0;
      r_vbits     <= '0;
    end else if (din_dv) begin
      r_exp_chn <= w_next_chn;
      r_phase   <= w_last ? ~w_eff_phase : w_eff_phase;
      r_vbits   <= w_vbits_nxt;
      if (sync_in) begin
        r_err       <= 1'b0;
        r_sync_pend <= 1'b1;
      end else begin
        if (din_chn != r_exp_chn) r_err <= 1'b1;
        if (w_issue) r_sync_pend <= 1'b0;
      end
    end
  end

  // Buffer write in phase 0 and registered buffer read for an issuing pair
  always_ff @(posedge clk) begin
    if (w_write) r_mem[w_addr] <= din_dq;
    if (w_issue) r_p1_rd <= r_mem[w_addr];
    r_p2_rd <= r_p1_rd;
  end

  // Pair pipeline; reset cancels any pair in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_vld  <= 1'b0;
      r_p1_sync <= 1'b0;
      r_p1_chn  <= 8'd0;
      r_p1_dq   <= 16'd0;
      r_p2_vld  <= 1'b0;
      r_p2_sync <= 1'b0;
      r_p2_chn  <= 8'd0;
      r_p2_dq   <= 16'd0;
    end else begin
      r_p1_vld  <= w_issue;
      r_p1_sync <= w_issue & r_sync_pend;
      if (w_issue) begin
        r_p1_chn <= din_chn;
        r_p1_dq  <= din_dq;
      end
      r_p2_vld  <= r_p1_vld;
      r_p2_sync <= r_p1_sync;
      r_p2_chn  <= r_p1_chn;
      r_p2_dq   <= r_p1_dq;
    end
  end

  // Output stage: one-cycle valid pulse, data held between pairs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv       <= 1'b0;
      r_sync_out <= 1'b0;
      r_dp1      <= 16'd0;
      r_dp2      <= 16'd0;
      r_chn      <= 8'd0;
    end else begin
      r_dv       <= r_p2_vld;
      r_sync_out <= r_p2_sync;
      if (r_p2_vld) begin
        r_dp1 <= r_p2_dq;
        r_dp2 <= r_p2_rd;
        r_chn <= r_p2_chn;
      end
    end
  end

  assign dout_dp1 = r_dp1;
  assign dout_dp2 = r_dp2;
  assign dout_dv  = r_dv;
  assign dout_chn = r_chn;
  assign sync_out = r_sync_out;
  assign err_seq  = r_err;

endmodule
